enemy_wave_control: RTL and testbench
=====================================

Name: enemy_wave_control

Overview:
- Multi-channel successor to the single-enemy control path: owns N enemy slots, its own speed/spawn prescalers, a pseudo-random spawn source and per-slot movement toward one of several bases.
- Sits in the game-logic layer between the timing domain and the vector renderer.
- Reports positions, alive flags, base-hit events and kill count to the HUD/score logic.

Parameters:
- N_ENEMIES, 4: number of enemy slots (1..16).
- OUT_WIDTH, 8: coordinate width.
- N_BASES, 3: number of target bases (1..8).
- SPEED_DIV, 2_500_000: clk cycles per movement tick.
- SPAWN_DIV, 100_000_000: clk cycles per spawn attempt.
- Y_GROUND, 240: y value at which an enemy reaches its base; must be below 2^OUT_WIDTH.
- LFSR_SEED, 16'hACE1: reset value of the spawn LFSR; must be non-zero.

Ports:
- clk  in  1: system clock (100 MHz).
- rst  in  1: asynchronous, active-low reset.
- en  in  1: run enable. Low freezes prescalers, movement and spawning.
- kill  in  N_ENEMIES: per-slot kill request from the collision logic, level-sampled.
- xenemy  out  N_ENEMIES*OUT_WIDTH: packed x coordinates. Slot i occupies [i*OUT_WIDTH +: OUT_WIDTH].
- yenemy  out  N_ENEMIES*OUT_WIDTH: packed y coordinates, same packing.
- alive  out  N_ENEMIES: slot active flags.
- base_hit  out  1: one-cycle pulse when any enemy reaches ground.
- base_id  out  3: base index of the most recent hit; valid while base_hit is high.
- spawn_missed  out  1: one-cycle pulse when a spawn tick finds no free slot.
- kill_count  out  16: number of accepted kills, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs, prescalers and slot state are 0.
  - LFSR is loaded with LFSR_SEED.
- Prescalers:
  - Two free-running counters, advanced only when en=1.
  - speed_tick is high for 1 cycle when the speed counter equals SPEED_DIV-1; the counter then wraps to 0.
  - spawn_tick works the same way using SPAWN_DIV-1.
  - en=0 holds both counters; no ticks are generated.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Steps every clk cycle regardless of en.
- Per-slot FSM, states FREE and ACTIVE:
  - FREE -> ACTIVE on a spawn allocation.
  - ACTIVE -> FREE on an accepted kill or on ground arrival.
  - alive[i] = (state == ACTIVE).
  - A FREE slot holds x/y at 0.
- Spawn:
  - On spawn_tick, the lowest-index FREE slot is allocated.
  - Allocated slot gets x = lfsr[OUT_WIDTH-1:0], y = 0, target base = lfsr[15:8] mod N_BASES.
  - Target x = (2*b+1)*2^OUT_WIDTH / (2*N_BASES), computed as an elaboration-time constant table.
  - If no slot is free, spawn_missed pulses for 1 cycle and nothing changes.
  - alive goes high on the cycle after spawn_tick (1-cycle latency).
- Movement, on speed_tick for each ACTIVE slot:
  - y increments by 1.
  - x steps by 1 toward the target x; x is unchanged if already equal.
  - x never overshoots the target.
- Ground arrival:
  - Triggered when an ACTIVE slot's updated y equals Y_GROUND.
  - The slot goes FREE on the next cycle.
  - base_hit pulses for 1 cycle and base_id takes that slot's base.
  - If several slots arrive in the same cycle, the lowest index is reported. The others are freed silently and counted as a single base_hit.
- Kill:
  - kill[i] high while slot i is ACTIVE frees the slot on the next cycle.
  - kill_count increments by the number of slots killed that cycle, saturating at 16'hFFFF.
  - kill on a FREE slot is ignored.
  - Kills are accepted even when en=0.
- Simultaneous events:
  - Kill and ground arrival on the same slot in the same cycle: the kill wins; no base_hit, kill_count increments.
  - Kill and re-spawn of the same slot in the same cycle: the kill frees the slot first, but allocation only considers slots that were FREE at the start of the cycle, so that slot is not re-spawned this cycle.
- Reset mid-operation:
  - All slots go FREE immediately and pending pulses are dropped.
  - The LFSR reloads LFSR_SEED, so the spawn sequence is repeatable after reset.

Test Plan:
- Setup for all scenarios: N_ENEMIES=4, N_BASES=2, OUT_WIDTH=8, SPEED_DIV=4, SPAWN_DIV=16, Y_GROUND=10.
1. Reset then en=1 -> first spawn_tick at cycle 15. Slot 0 alive at cycle 16 with y=0 and x equal to the LFSR low byte. alive stays 4'b0000 beforehand.
2. Slot 0 spawned with target base 0 (x=64) -> y increments every 4 cycles and x moves 1 toward 64 per tick. After the 10th tick, base_hit=1 for exactly 1 cycle with base_id=0, and alive[0]=0 on the next cycle.
3. Let 4 spawns fill all slots, with no kills and Y_GROUND unreachable (set to 200) -> 5th spawn_tick gives spawn_missed=1 for 1 cycle and alive stays 4'b1111.
4. Assert kill=4'b0101 for 1 cycle with slots 0-3 alive -> alive=4'b1010 next cycle and kill_count=2. Re-asserting kill=4'b0101 has no effect.
5. Arrange kill[1] in the same cycle as slot 1 reaches Y_GROUND -> no base_hit, kill_count +1, slot 1 freed.
6. Hold en=0 for 50 cycles mid-flight -> positions, prescalers and alive are unchanged, and kill is still accepted. Pulling rst low mid-flight -> all outputs 0 asynchronously; after release the first spawn x matches scenario 1.

Source files
------------

// File: rtl/enemy_wave_control.sv
// Enemy wave controller: N slots spawned from an LFSR on a slow tick, each marching toward one of several bases.
// Latency: spawn, kill and ground-arrival effects appear one cycle after the tick or kill sample that caused them.
// Backpressure: none; a spawn tick that finds every slot busy is dropped and flagged on spawn_missed.
module enemy_wave_control #(
    parameter int          N_ENEMIES = 4,
    parameter int          OUT_WIDTH = 8,
    parameter int          N_BASES   = 3,
    parameter int          SPEED_DIV = 2_500_000,
    parameter int          SPAWN_DIV = 100_000_000,
    parameter int          Y_GROUND  = 240,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [N_ENEMIES-1:0]           kill,
    output logic [N_ENEMIES*OUT_WIDTH-1:0] xenemy,
    output logic [N_ENEMIES*OUT_WIDTH-1:0] yenemy,
    output logic [N_ENEMIES-1:0]           alive,
    output logic                           base_hit,
    output logic [2:0]                     base_id,
    output logic                           spawn_missed,
    output logic [15:0]                    kill_count
);

    localparam int SPD_W  = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
    localparam int SPN_W  = (SPAWN_DIV > 1) ? $clog2(SPAWN_DIV) : 1;
    localparam int BASE_W = (N_BASES > 1) ? $clog2(N_BASES) : 1;
    localparam logic [SPD_W-1:0]     SPD_LAST = SPD_W'(SPEED_DIV - 1);
    localparam logic [SPN_W-1:0]     SPN_LAST = SPN_W'(SPAWN_DIV - 1);
    localparam logic [OUT_WIDTH-1:0] Y_GND    = OUT_WIDTH'(Y_GROUND);

    // Base b sits at the centre of the b-th of N_BASES equal strips across the screen.
    function automatic logic [N_BASES*OUT_WIDTH-1:0] calc_targets();
        logic [N_BASES*OUT_WIDTH-1:0] t;
        t = '0;
        for (int b = 0; b < N_BASES; b++)
            t[b*OUT_WIDTH +: OUT_WIDTH] =
                OUT_WIDTH'((longint'(2*b + 1) << OUT_WIDTH) / longint'(2*N_BASES));
        return t;
    endfunction

    localparam logic [N_BASES*OUT_WIDTH-1:0] TARGET_X = calc_targets();

    typedef enum logic {FREE = 1'b0, ACTIVE = 1'b1} slot_state_t;

    slot_state_t          state  [N_ENEMIES];
    logic [OUT_WIDTH-1:0] x_q    [N_ENEMIES];
    logic [OUT_WIDTH-1:0] y_q    [N_ENEMIES];
    logic [BASE_W-1:0]    base_q [N_ENEMIES];
    logic [SPD_W-1:0]     speed_cnt;
    logic [SPN_W-1:0]     spawn_cnt;
    logic [15:0]          lfsr;

    logic                 speed_tick;
    logic                 spawn_tick;
    logic                 lfsr_fb;
    logic [BASE_W-1:0]    spawn_base;
    logic [N_ENEMIES-1:0] is_active;
    logic [N_ENEMIES-1:0] killed;
    logic [N_ENEMIES-1:0] arrive;
    logic [N_ENEMIES-1:0] alloc;
    logic [OUT_WIDTH-1:0] tgt_x  [N_ENEMIES];
    logic [OUT_WIDTH-1:0] x_step [N_ENEMIES];
    logic [OUT_WIDTH-1:0] y_step [N_ENEMIES];
    logic                 any_free;
    logic                 any_hit;
    logic [BASE_W-1:0]    hit_base;
    logic [4:0]           n_kill;
    logic [16:0]          kill_sum;

    assign speed_tick = en && (speed_cnt == SPD_LAST);
    assign spawn_tick = en && (spawn_cnt == SPN_LAST);
    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign spawn_base = BASE_W'({8'd0, lfsr[15:8]} % 16'(N_BASES));
    assign kill_sum   = {1'b0, kill_count} + {12'd0, n_kill};
    assign alive      = is_active;

    // Allocation looks only at slots free at the start of the cycle, so a slot
    // being killed or landing this cycle is never re-spawned in the same cycle.
    always_comb begin
        any_free = 1'b0;
        any_hit  = 1'b0;
        hit_base = '0;
        n_kill   = '0;
        alloc    = '0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            is_active[i] = (state[i] == ACTIVE);
            killed[i]    = kill[i] && is_active[i];
            tgt_x[i]     = TARGET_X[int'(base_q[i])*OUT_WIDTH +: OUT_WIDTH];
            y_step[i]    = y_q[i] + 1'b1;
            if (x_q[i] < tgt_x[i])
                x_step[i] = x_q[i] + 1'b1;
            else if (x_q[i] > tgt_x[i])
                x_step[i] = x_q[i] - 1'b1;
            else
                x_step[i] = x_q[i];
            arrive[i] = is_active[i] && speed_tick && (y_step[i] == Y_GND);
            if (killed[i])
                n_kill = n_kill + 1'b1;
            if (arrive[i] && !killed[i] && !any_hit) begin
                any_hit  = 1'b1;
                hit_base = base_q[i];
            end
            if (!is_active[i] && !any_free) begin
                alloc[i] = 1'b1;
                any_free = 1'b1;
            end
        end
    end

    always_comb begin
        xenemy = '0;
        yenemy = '0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            xenemy[i*OUT_WIDTH +: OUT_WIDTH] = x_q[i];
            yenemy[i*OUT_WIDTH +: OUT_WIDTH] = y_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            speed_cnt    <= '0;
            spawn_cnt    <= '0;
            lfsr         <= LFSR_SEED;
            base_hit     <= 1'b0;
            base_id      <= '0;
            spawn_missed <= 1'b0;
            kill_count   <= '0;
            for (int i = 0; i < N_ENEMIES; i++) begin
                state[i]  <= FREE;
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                base_q[i] <= '0;
            end
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            if (en) begin
                speed_cnt <= speed_tick ? '0 : speed_cnt + 1'b1;
                spawn_cnt <= spawn_tick ? '0 : spawn_cnt + 1'b1;
            end
            base_hit     <= any_hit;
            spawn_missed <= spawn_tick && !any_free;
            if (any_hit)
                base_id <= 3'(hit_base);
            if (n_kill != '0)
                kill_count <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
            for (int i = 0; i < N_ENEMIES; i++) begin
                case (state[i])
                    FREE: begin
                        if (spawn_tick && alloc[i]) begin
                            state[i]  <= ACTIVE;
                            x_q[i]    <= OUT_WIDTH'(lfsr);
                            y_q[i]    <= '0;
                            base_q[i] <= spawn_base;
                        end
                    end
                    ACTIVE: begin
                        // Kill takes priority over landing; both just release the slot.
                        if (killed[i] || arrive[i]) begin
                            state[i] <= FREE;
                            x_q[i]   <= '0;
                            y_q[i]   <= '0;
                        end else if (speed_tick) begin
                            x_q[i] <= x_step[i];
                            y_q[i] <= y_step[i];
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_enemy_wave_control.sv
// Bench for enemy_wave_control: directed cycle-exact sequences, a kill vector table and a spawn-x scoreboard.
module tb_enemy_wave_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  kill, kill_f;
    logic [31:0] xen, yen, xen_f, yen_f;
    logic [3:0]  alive, alive_f;
    logic        base_hit, base_hit_f;
    logic [2:0]  base_id, base_id_f;
    logic        spawn_missed, spawn_missed_f;
    logic [15:0] kill_count, kill_count_f;

    always #5 clk = ~clk;

    enemy_wave_control #(
        .N_ENEMIES(4), .OUT_WIDTH(8), .N_BASES(2), .SPEED_DIV(4),
        .SPAWN_DIV(16), .Y_GROUND(10), .LFSR_SEED(16'hACE1)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .kill(kill),
        .xenemy(xen), .yenemy(yen), .alive(alive),
        .base_hit(base_hit), .base_id(base_id),
        .spawn_missed(spawn_missed), .kill_count(kill_count)
    );

    enemy_wave_control #(
        .N_ENEMIES(4), .OUT_WIDTH(8), .N_BASES(2), .SPEED_DIV(4),
        .SPAWN_DIV(16), .Y_GROUND(200), .LFSR_SEED(16'hACE1)
    ) u_full (
        .clk(clk), .rst(rst), .en(en), .kill(kill_f),
        .xenemy(xen_f), .yenemy(yen_f), .alive(alive_f),
        .base_hit(base_hit_f), .base_id(base_id_f),
        .spawn_missed(spawn_missed_f), .kill_count(kill_count_f)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] v;
        v = 16'hACE1;
        for (int k = 0; k < n; k++)
            v = lfsr_step(v);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic run_to(input int n);
        while (t < n)
            step();
    endtask

    // Reference for the spawn source: prescaler and LFSR of the first instance.
    logic [15:0] m_lfsr;
    int          m_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr <= 16'hACE1;
            m_cnt  <= 0;
        end else begin
            m_lfsr <= lfsr_step(m_lfsr);
            if (en)
                m_cnt <= (m_cnt == 15) ? 0 : m_cnt + 1;
        end
    end

    // Scoreboard: expected spawn x pushed on each spawn tick, popped when a slot comes alive.
    logic [7:0] sb_q[$];
    logic [3:0] prev_alive;
    logic [3:0] rise;
    logic [7:0] exp_x;
    always @(negedge clk) begin
        if (!rst) begin
            sb_q.delete();
            prev_alive = 4'b0000;
        end else begin
            rise = alive & ~prev_alive;
            for (int i = 0; i < 4; i++) begin
                if (rise[i]) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", sb_q.size(), 1);
                    end else begin
                        exp_x = sb_q.pop_front();
                        chk("sb_spawn_x", int'(xen[i*8 +: 8]), int'(exp_x));
                        chk("sb_spawn_y", int'(yen[i*8 +: 8]), 0);
                    end
                end
            end
            if (en && m_cnt == 15)
                sb_q.push_back(m_lfsr[7:0]);
            prev_alive = alive;
        end
    end

    typedef struct {
        logic [3:0] kill;
        logic [3:0] exp_alive;
        int         exp_count;
    } kvec_t;

    kvec_t kv [5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] l15;
        logic [15:0] l47;
        logic [7:0]  x0_exp;
        logic [7:0]  tgt;
        logic [7:0]  ex;

        kv[0] = '{4'b0101, 4'b1010, 2};
        kv[1] = '{4'b0101, 4'b1010, 2};
        kv[2] = '{4'b1000, 4'b0010, 3};
        kv[3] = '{4'b0010, 4'b0000, 4};
        kv[4] = '{4'b0001, 4'b0000, 4};

        l15    = lfsr_at(15);
        l47    = lfsr_at(47);
        x0_exp = l15[7:0];
        tgt    = l15[8] ? 8'd192 : 8'd64;

        rst = 1'b0; en = 1'b0; kill = '0; kill_f = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alive", alive, 0);
        chk("rst_x", xen, 0);
        chk("rst_y", yen, 0);
        chk("rst_kill_count", kill_count, 0);
        chk("rst_base_hit", base_hit, 0);
        chk("rst_spawn_missed", spawn_missed, 0);

        rst = 1'b1; en = 1'b1; t = 0;
        run_to(15);
        chk("pre_spawn_alive", alive, 0);
        run_to(16);
        chk("spawn0_alive", alive, 4'b0001);
        chk("spawn0_x", xen[7:0], x0_exp);
        chk("spawn0_y", yen[7:0], 0);

        ex = x0_exp;
        for (int k = 1; k <= 9; k++) begin
            run_to(16 + 4*k);
            if (ex < tgt) ex = ex + 8'd1;
            else if (ex > tgt) ex = ex - 8'd1;
            chk("move_y", yen[7:0], k);
            chk("move_x", xen[7:0], ex);
        end
        run_to(56);
        chk("ground_hit", base_hit, 1);
        chk("ground_id", base_id, int'(l15[8]));
        chk("ground_free", alive[0], 0);
        run_to(57);
        chk("ground_pulse_end", base_hit, 0);

        // Slot 1 (spawned at 32) lands during cycle 71; a simultaneous kill must win.
        run_to(71); kill = 4'b0010;
        run_to(72); kill = 4'b0000;
        chk("kill_vs_ground_hit", base_hit, 0);
        chk("kill_vs_ground_alive", alive[1], 0);
        chk("kill_vs_ground_count", kill_count, 1);
        run_to(73); kill = 4'b0010;
        run_to(74); kill = 4'b0000;
        chk("kill_free_ignored", kill_count, 1);

        run_to(79);
        chk("full_alive", alive_f, 4'b1111);
        chk("full_no_miss_yet", spawn_missed_f, 0);
        run_to(80);
        chk("full_spawn_missed", spawn_missed_f, 1);
        chk("full_alive_held", alive_f, 4'b1111);
        run_to(81);
        chk("full_miss_pulse_end", spawn_missed_f, 0);

        for (int i = 0; i < 5; i++) begin
            kill_f = kv[i].kill;
            step();
            kill_f = 4'b0000;
            chk("kvec_alive", alive_f, kv[i].exp_alive);
            chk("kvec_count", kill_count_f, kv[i].exp_count);
        end

        run_to(88);
        chk("ground2_hit", base_hit, 1);
        chk("ground2_id", base_id, int'(l47[8]));

        run_to(92);
        chk("pre_freeze_alive", alive, 4'b0011);
        chk("pre_freeze_y0", yen[7:0], 7);
        chk("pre_freeze_y1", yen[15:8], 3);
        en = 1'b0;
        run_to(100); kill = 4'b0001;
        run_to(101); kill = 4'b0000;
        run_to(142);
        chk("freeze_alive", alive, 4'b0010);
        chk("freeze_y1", yen[15:8], 3);
        chk("freeze_slot0_cleared", xen[7:0] | yen[7:0], 0);
        chk("freeze_kill_count", kill_count, 2);
        en = 1'b1;
        run_to(145);
        chk("resume_y1_hold", yen[15:8], 3);
        run_to(146);
        chk("resume_y1_step", yen[15:8], 4);

        run_to(150);
        rst = 1'b0;
        #1;
        chk("arst_alive", alive, 0);
        chk("arst_x", xen, 0);
        chk("arst_y", yen, 0);
        chk("arst_kill_count", kill_count, 0);
        chk("arst_full_alive", alive_f, 0);
        chk("arst_full_kill_count", kill_count_f, 0);
        step();
        rst = 1'b1; t = 0;
        run_to(15);
        chk("rerun_pre_alive", alive, 0);
        run_to(16);
        chk("rerun_alive", alive, 4'b0001);
        chk("rerun_x", xen[7:0], x0_exp);

        en = 1'b0;
        step();
        step();
        chk("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
